mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 100 ++++++++++
 tb/tb_mem_access_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// SRAM access controller: freezes the pipeline for 1+WAIT_CYCLES cycles per load/store.
// Optional posted-write buffer enabled by defining MEM_WBUF_EN.
module mem_access_ctrl #(
  parameter int          WAIT_CYCLES = 4,
  parameter int          ADDR_W      = 18,
  parameter logic [31:0] MEM_BASE    = 32'd1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       val_rm,
  input  logic [31:0]       sram_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_we_n,
  output logic              freeze,
  output logic [31:0]       rd_data,
  output logic              rd_valid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_is_write;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [31:0]       r_sram_wdata;
  logic [31:0]       r_rd_data;
  logic              r_rd_valid;

  logic              w_op;
  logic              w_posted;
  logic [31:0]       w_addr_off;
  logic              w_last;

  assign w_op       = mem_read | mem_write;
  assign w_addr_off = alu_result - MEM_BASE;
  assign w_last     = (r_state == S_ACCESS) && (r_cnt == LAST_CNT);

`ifdef MEM_WBUF_EN
  assign w_posted = (r_state == S_IDLE) & mem_write & ~mem_read;
`else
  assign w_posted = 1'b0;
`endif

  assign freeze     = w_op & (r_state != S_DONE) & ~w_posted;
  assign sram_we_n  = ~((r_state == S_ACCESS) & r_is_write);
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_is_write   <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_op) begin
            r_sram_addr  <= ADDR_W'(w_addr_off >> 2);
            r_sram_wdata <= val_rm;
            r_is_write   <= ~mem_read;
            r_cnt        <= '0;
            r_state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            if (!r_is_write) begin
              r_rd_data  <= sram_rdata;
              r_rd_valid <= 1'b1;
            end
`ifdef MEM_WBUF_EN
            // Posted writes drain straight back to IDLE; the pipeline was never held.
            r_state <= r_is_write ? S_IDLE : S_DONE;
`else
            r_state <= S_DONE;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus a randomized pipeline
// checked every cycle against a transaction-timeline model.
module tb_mem_access_ctrl;

  localparam int          WAIT   = 4;
  localparam int          AW     = 18;
  localparam logic [31:0] BASE   = 32'd1024;
`ifdef MEM_WBUF_EN
  localparam bit          WBUF   = 1'b1;
`else
  localparam bit          WBUF   = 1'b0;
`endif

  logic          clk, rst, mem_read, mem_write;
  logic [31:0]   alu_result, val_rm, sram_rdata;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, rd_data;
  logic          sram_we_n, freeze, rd_valid;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl #(.WAIT_CYCLES(WAIT), .ADDR_W(AW), .MEM_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .alu_result(alu_result), .val_rm(val_rm), .sram_rdata(sram_rdata),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we_n(sram_we_n),
    .freeze(freeze), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Timeline model: an op accepted in IDLE at cycle s occupies s+1..s+WAIT in access
  // and, unless posted, reports completion at s+WAIT+1.
  int          cyc = 0;
  int          m_start = 0;
  bit          m_active = 0, m_posted = 0, m_rd_op = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_pend = 0, m_rd = 0;

  always @(negedge clk) begin
    logic op, e_frz, e_we_n, e_rv;
    int k;
    cyc++;
    op = mem_read | mem_write;
    if (rst) begin
      m_active = 0;
      m_rd     = 0;
      e_frz    = op & ~(WBUF & mem_write & ~mem_read);
      chk("rst_addr", 32'(sram_addr), 0);
      chk("rst_wdata", sram_wdata, 0);
      chk("rst_we_n", 32'(sram_we_n), 1);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_freeze", 32'(freeze), 32'(e_frz));
    end else begin
      k      = cyc - m_start;
      e_we_n = 1'b1;
      e_rv   = 1'b0;
      if (m_active && k >= 1 && k <= WAIT) begin
        e_frz  = op;
        e_we_n = m_rd_op;
        if (k == WAIT) m_pend = sram_rdata;
        chk("m_addr", 32'(sram_addr), m_addr);
        chk("m_wdata", sram_wdata, m_wdata);
      end else if (m_active && k == WAIT + 1 && !m_posted) begin
        e_frz = 1'b0;
        e_rv  = m_rd_op;
        if (m_rd_op) m_rd = m_pend;
        m_active = 0;
      end else begin
        m_active = 0;
        m_posted = WBUF && mem_write && !mem_read;
        e_frz    = op && !m_posted;
        if (op) begin
          m_active = 1;
          m_start  = cyc;
          m_rd_op  = mem_read;
          m_addr   = 32'(AW'((alu_result - BASE) / 4));
          m_wdata  = val_rm;
        end
      end
      chk("m_freeze", 32'(freeze), 32'(e_frz));
      chk("m_we_n", 32'(sram_we_n), 32'(e_we_n));
      chk("m_rd_valid", 32'(rd_valid), 32'(e_rv));
      chk("m_rd_data", rd_data, m_rd);
    end
  end

  task automatic run_op(input logic rd, input logic wr, input logic [31:0] a, v, rdat,
                        output int nfz, output int nwe, output logic v6, fz7, rv7,
                        output logic [31:0] d6, a2, w2);
    nfz = 0; nwe = 0; v6 = 0; d6 = 0; a2 = 0; w2 = 0;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; alu_result = a; val_rm = v; sram_rdata = rdat;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (freeze) nfz++;
      if (!sram_we_n) nwe++;
      if (i == 2) begin a2 = 32'(sram_addr); w2 = sram_wdata; end
      if (i == 6) begin v6 = rd_valid; d6 = rd_data; end
    end
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
    @(negedge clk);
    fz7 = freeze; rv7 = rd_valid;
  endtask

  initial begin
    int nfz, nwe;
    logic v6, fz7, rv7, f;
    logic [31:0] d6, a2, w2;
    rst = 1; mem_read = 0; mem_write = 0; alu_result = 0; val_rm = 0; sram_rdata = 0;
    repeat (2) @(negedge clk);
    chk("reset_we_n", 32'(sram_we_n), 1);
    chk("reset_freeze", 32'(freeze), 0);
    @(posedge clk); #1 rst = 0;
    repeat (2) @(negedge clk);

    run_op(1, 0, 32'd1028, 32'h0, 32'hDEADBEEF, nfz, nwe, v6, fz7, rv7, d6, a2, w2);
    chk("rd_freeze_cycles", nfz, 5);
    chk("rd_addr", a2, 1);
    chk("rd_valid_c6", 32'(v6), 1);
    chk("rd_data_c6", d6, 32'hDEADBEEF);
    chk("rd_no_we", nwe, 0);
    chk("rd_idle_freeze", 32'(fz7), 0);
    chk("rd_idle_valid", 32'(rv7), 0);

`ifndef MEM_WBUF_EN
    run_op(0, 1, 32'd1024, 32'h12345678, 32'h0, nfz, nwe, v6, fz7, rv7, d6, a2, w2);
    chk("wr_we_cycles", nwe, 4);
    chk("wr_addr", a2, 0);
    chk("wr_wdata", w2, 32'h12345678);
    chk("wr_freeze_cycles", nfz, 5);
    chk("wr_no_valid", 32'(v6), 0);
`endif

    run_op(1, 1, 32'd1064, 32'h55AA55AA, 32'hCAFEF00D, nfz, nwe, v6, fz7, rv7, d6, a2, w2);
    chk("both_no_we", nwe, 0);
    chk("both_addr", a2, 10);
    chk("both_valid", 32'(v6), 1);
    chk("both_data", d6, 32'hCAFEF00D);

    // Reset during the second access cycle of a write.
    @(posedge clk); #1;
    mem_write = 1; alu_result = 32'd1032; val_rm = 32'hA5A5A5A5;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1; mem_write = 0;
    #1;
    chk("midrst_we_n", 32'(sram_we_n), 1);
    chk("midrst_freeze", 32'(freeze), 0);
    chk("midrst_rd_data", rd_data, 0);
    @(negedge clk);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);

    run_op(1, 0, BASE - 32'd4, 32'h0, 32'h0BADF00D, nfz, nwe, v6, fz7, rv7, d6, a2, w2);
    chk("wrap_addr", a2, 32'h3FFFF);
    chk("wrap_freeze_cycles", nfz, 5);
    chk("wrap_data", d6, 32'h0BADF00D);

    // Randomized pipeline: a new instruction enters only when the previous cycle was not frozen.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      f = freeze;
      @(posedge clk); #1;
      sram_rdata = $urandom;
      if (!f) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: begin mem_read = 1; mem_write = 0; end
          4, 5, 6:    begin mem_read = 0; mem_write = 1; end
          7:          begin mem_read = 1; mem_write = 1; end
          default:    begin mem_read = 0; mem_write = 0; end
        endcase
        if ($urandom_range(0, 3) == 0) alu_result = $urandom;
        else alu_result = BASE + ($urandom_range(0, 4095) << 2) + $urandom_range(0, 3);
        val_rm = $urandom;
      end
    end
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
